// File: rtl/gate_pair_scheduler_pkg.sv
// Shared types and constants for the gate pair scheduler.
//   slot_state_t   : per-slot FSM encoding
//   LFSR_*         : Galois LFSR feedback mask and the substitute for a zero seed
//   *_TBL          : 16-entry start-offset tables (40<=X<=629, 80<=Y<=389)
//   lfsr_next()    : one LFSR step
package gate_pkg;

   typedef enum logic [1:0] {SHOW, HIDE, PLACE} slot_state_t;

   localparam int          IDX_W          = 4;
   localparam logic [15:0] LFSR_MASK      = 16'hB400;
   localparam logic [15:0] LFSR_ZERO_SEED = 16'hACE1;

   // Entry 0 is the rightmost element of each concatenation.
   localparam logic [15:0][10:0] A_X_TBL = {
      11'd595, 11'd558, 11'd521, 11'd484, 11'd447, 11'd410, 11'd373, 11'd336,
      11'd299, 11'd262, 11'd225, 11'd188, 11'd151, 11'd114, 11'd77,  11'd40};
   localparam logic [15:0][10:0] A_Y_TBL = {
      11'd365, 11'd346, 11'd327, 11'd308, 11'd289, 11'd270, 11'd251, 11'd232,
      11'd213, 11'd194, 11'd175, 11'd156, 11'd137, 11'd118, 11'd99,  11'd80};
   localparam logic [15:0][10:0] B_X_TBL = {
      11'd74,  11'd111, 11'd148, 11'd185, 11'd222, 11'd259, 11'd296, 11'd333,
      11'd370, 11'd407, 11'd444, 11'd481, 11'd518, 11'd555, 11'd592, 11'd629};
   localparam logic [15:0][10:0] B_Y_TBL = {
      11'd134, 11'd151, 11'd168, 11'd185, 11'd202, 11'd219, 11'd236, 11'd253,
      11'd270, 11'd287, 11'd304, 11'd321, 11'd338, 11'd355, 11'd372, 11'd389};

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
   endfunction

endpackage

// File: rtl/gate_pair_scheduler_if.sv
// Bus between game-control logic (master) and the gate pair scheduler (slave).
//   pause        : freeze hide countdowns and the LFSR
//   change_coord : per-pair move request
//   A/B_offsetX/Y: per-pair start offsets, pair i at [i*COORD_W +: COORD_W]
//   visible      : per-pair offsets valid / pair drawn
//   busy         : some pair is not showing
interface gate_pair_scheduler_if #(
   parameter int NUM_PAIRS = 2,
   parameter int COORD_W   = 11
);
   logic                           pause;
   logic [NUM_PAIRS-1:0]           change_coord;
   logic [NUM_PAIRS*COORD_W-1:0]   A_offsetX;
   logic [NUM_PAIRS*COORD_W-1:0]   A_offsetY;
   logic [NUM_PAIRS*COORD_W-1:0]   B_offsetX;
   logic [NUM_PAIRS*COORD_W-1:0]   B_offsetY;
   logic [NUM_PAIRS-1:0]           visible;
   logic                           busy;

   modport master (
      output pause, change_coord,
      input  A_offsetX, A_offsetY, B_offsetX, B_offsetY, visible, busy
   );

   modport slave (
      input  pause, change_coord,
      output A_offsetX, A_offsetY, B_offsetX, B_offsetY, visible, busy
   );
endinterface

// File: rtl/gate_pair_slot.sv
// One gate pair: slot FSM, hide counter and offset registers.
//   CLK, resetN  : clock, async active-low reset
//   pause        : freezes the hide countdown only
//   change_coord : move request for this pair
//   rnd          : low byte of the shared LFSR
//   a_x..b_y     : start offsets of gate A and gate B
//   visible      : offsets valid
//   busy         : slot not in SHOW
//
//   state | meaning
//   ------+------------------------------------------------------
//   PLACE | load offsets from tables at (rnd nibble + SLOT_IDX), 1 cycle
//   SHOW  | offsets held and visible; a request starts a hide
//   HIDE  | offsets 0, hidden for HIDE_CYCLES unpaused cycles
module gate_pair_slot
   import gate_pkg::*;
#(
   parameter int COORD_W     = 11,
   parameter int HIDE_CYCLES = 3,
   parameter int SLOT_IDX    = 0
) (
   input  logic               CLK,
   input  logic               resetN,
   input  logic               pause,
   input  logic               change_coord,
   input  logic [7:0]         rnd,
   output logic [COORD_W-1:0] a_x,
   output logic [COORD_W-1:0] a_y,
   output logic [COORD_W-1:0] b_x,
   output logic [COORD_W-1:0] b_y,
   output logic               visible,
   output logic               busy
);
   localparam int                CNT_W    = $clog2(HIDE_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(HIDE_CYCLES - 1);
   localparam logic [IDX_W-1:0]  IDX_OFS  = IDX_W'(SLOT_IDX);

   slot_state_t        state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [COORD_W-1:0] a_x_n, a_y_n, b_x_n, b_y_n;
   logic               visible_n;
   logic [IDX_W-1:0]   ia, ib;

   // Same LFSR value in every slot; the per-slot offset keeps indices apart.
   assign ia = rnd[3:0] + IDX_OFS;
   assign ib = rnd[7:4] + IDX_OFS;

   always_ff @(posedge CLK or negedge resetN) begin
      if (!resetN) begin
         state   <= PLACE;
         cnt     <= '0;
         a_x     <= '0;
         a_y     <= '0;
         b_x     <= '0;
         b_y     <= '0;
         visible <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         a_x     <= a_x_n;
         a_y     <= a_y_n;
         b_x     <= b_x_n;
         b_y     <= b_y_n;
         visible <= visible_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      a_x_n     = a_x;
      a_y_n     = a_y;
      b_x_n     = b_x;
      b_y_n     = b_y;
      visible_n = visible;
      case (state)
         PLACE: begin
            a_x_n     = COORD_W'(A_X_TBL[ia]);
            a_y_n     = COORD_W'(A_Y_TBL[ia]);
            b_x_n     = COORD_W'(B_X_TBL[ib]);
            b_y_n     = COORD_W'(B_Y_TBL[ib]);
            visible_n = 1'b1;
            state_n   = SHOW;
         end
         SHOW: begin
            if (change_coord) begin
               a_x_n     = '0;
               a_y_n     = '0;
               b_x_n     = '0;
               b_y_n     = '0;
               visible_n = 1'b0;
               cnt_n     = CNT_LOAD;
               state_n   = HIDE;
            end
         end
         HIDE: begin
            if (!pause) begin
               if (cnt == '0) state_n = PLACE;
               else           cnt_n   = cnt - 1'b1;
            end
         end
         default: state_n = PLACE;
      endcase
   end

   assign busy = (state != SHOW);

endmodule

// File: rtl/gate_pair_scheduler.sv
// Places NUM_PAIRS independent gate pairs; each hides and re-appears at a
// pseudo-random table position on request.
//   CLK, resetN : clock, async active-low reset
//   seed        : LFSR seed, loaded while resetN=0 (0 maps to LFSR_ZERO_SEED)
//   bus         : slave side of gate_pair_scheduler_if
module gate_pair_scheduler
   import gate_pkg::*;
#(
   parameter int NUM_PAIRS   = 2,
   parameter int COORD_W     = 11,
   parameter int HIDE_CYCLES = 50_000_000
) (
   input  logic        CLK,
   input  logic        resetN,
   input  logic [15:0] seed,
   gate_pair_scheduler_if.slave bus
);
   logic [15:0]          lfsr;
   logic [NUM_PAIRS-1:0] busy_vec;

   // Seed is loaded continuously during reset so the value at release wins.
   always_ff @(posedge CLK or negedge resetN) begin
      if (!resetN)         lfsr <= (seed == 16'h0) ? LFSR_ZERO_SEED : seed;
      else if (!bus.pause) lfsr <= lfsr_next(lfsr);
   end

   for (genvar i = 0; i < NUM_PAIRS; i++) begin : g_slot
      gate_pair_slot #(
         .COORD_W     (COORD_W),
         .HIDE_CYCLES (HIDE_CYCLES),
         .SLOT_IDX    (i)
      ) u_slot (
         .CLK          (CLK),
         .resetN       (resetN),
         .pause        (bus.pause),
         .change_coord (bus.change_coord[i]),
         .rnd          (lfsr[7:0]),
         .a_x          (bus.A_offsetX[i*COORD_W +: COORD_W]),
         .a_y          (bus.A_offsetY[i*COORD_W +: COORD_W]),
         .b_x          (bus.B_offsetX[i*COORD_W +: COORD_W]),
         .b_y          (bus.B_offsetY[i*COORD_W +: COORD_W]),
         .visible      (bus.visible[i]),
         .busy         (busy_vec[i])
      );
   end

   assign bus.busy = |busy_vec;

endmodule

// File: tb/tb_gate_pair_scheduler.sv
module tb_gate_pair_scheduler;
   logic        CLK;
   logic        resetN;
   logic [15:0] seed;
   int          checks   = 0;
   int          failures = 0;
   logic [15:0] m_lfsr, m_prev;

   gate_pair_scheduler_if #(.NUM_PAIRS(2), .COORD_W(11)) bus ();

   gate_pair_scheduler #(
      .NUM_PAIRS   (2),
      .COORD_W     (11),
      .HIDE_CYCLES (3)
   ) dut (
      .CLK    (CLK),
      .resetN (resetN),
      .seed   (seed),
      .bus    (bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Reference LFSR; m_prev is the value the DUT saw in the cycle just ended.
   always @(posedge CLK or negedge resetN) begin
      if (!resetN) begin
         m_lfsr <= (seed == 16'h0) ? 16'hACE1 : seed;
         m_prev <= (seed == 16'h0) ? 16'hACE1 : seed;
      end else begin
         m_prev <= m_lfsr;
         if (!bus.pause) m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
      end
   end

   function automatic logic [43:0] exp_pair(input int i, input logic [15:0] l);
      int ia, ib;
      ia = (int'(l[3:0]) + i) % 16;
      ib = (int'(l[7:4]) + i) % 16;
      return {11'(40 + 37*ia), 11'(80 + 19*ia), 11'(629 - 37*ib), 11'(389 - 17*ib)};
   endfunction

   function automatic logic [43:0] got_pair(input int i);
      return {bus.A_offsetX[i*11 +: 11], bus.A_offsetY[i*11 +: 11],
              bus.B_offsetX[i*11 +: 11], bus.B_offsetY[i*11 +: 11]};
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      seed = 16'h0001; resetN = 1'b0; bus.pause = 1'b0; bus.change_coord = 2'b00;
      tick(); tick();
      checks++;
      if (bus.visible !== 2'b00) begin failures++; $display("FAIL reset_visible got=%b exp=00", bus.visible); end
      checks++;
      if ({got_pair(0), got_pair(1)} !== 88'h0) begin failures++; $display("FAIL reset_offsets got=%h exp=0", {got_pair(0), got_pair(1)}); end
      checks++;
      if (bus.busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", bus.busy); end
      resetN = 1'b1;
      tick();
      checks++;
      if (bus.visible !== 2'b11) begin failures++; $display("FAIL first_visible got=%b exp=11", bus.visible); end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (got_pair(i) !== exp_pair(i, 16'h0001)) begin
            failures++; $display("FAIL first_offsets pair%0d got=%h exp=%h", i, got_pair(i), exp_pair(i, 16'h0001));
         end
      end
      checks++;
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL first_busy got=%b exp=0", bus.busy); end
   endtask

   task automatic test_move();
      logic [43:0] keep1;
      keep1 = got_pair(1);
      bus.change_coord = 2'b01;
      tick();
      bus.change_coord = 2'b00;
      checks++;
      if (bus.visible !== 2'b10) begin failures++; $display("FAIL move_visible got=%b exp=10", bus.visible); end
      checks++;
      if (got_pair(0) !== 44'h0) begin failures++; $display("FAIL move_pair0_zero got=%h exp=0", got_pair(0)); end
      checks++;
      if (got_pair(1) !== keep1) begin failures++; $display("FAIL move_pair1_hold got=%h exp=%h", got_pair(1), keep1); end
      checks++;
      if (bus.busy !== 1'b1) begin failures++; $display("FAIL move_busy got=%b exp=1", bus.busy); end
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++;
         if (bus.visible[0] !== (k == 4)) begin
            failures++; $display("FAIL move_latency t+%0d got=%b exp=%b", k + 1, bus.visible[0], (k == 4));
         end
      end
      checks++;
      if (got_pair(0) !== exp_pair(0, m_prev)) begin
         failures++; $display("FAIL move_new_offsets got=%h exp=%h", got_pair(0), exp_pair(0, m_prev));
      end
   endtask

   task automatic test_pause();
      bus.change_coord = 2'b01;
      tick();
      bus.change_coord = 2'b00;
      bus.pause = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         tick();
         if (k == 10) bus.pause = 1'b0;
         checks++;
         if (bus.visible[0] !== (k == 14)) begin
            failures++; $display("FAIL pause_extend t+%0d got=%b exp=%b", k + 1, bus.visible[0], (k == 14));
         end
      end
      checks++;
      if (got_pair(0) !== exp_pair(0, m_prev)) begin
         failures++; $display("FAIL pause_lfsr_offsets got=%h exp=%h", got_pair(0), exp_pair(0, m_prev));
      end
   endtask

   task automatic test_ignored();
      bus.change_coord = 2'b10;
      tick();
      bus.change_coord = 2'b00;
      checks++;
      if (bus.visible[1] !== 1'b0) begin failures++; $display("FAIL ignored_hide got=%b exp=0", bus.visible[1]); end
      for (int k = 1; k <= 8; k++) begin
         if (k == 1) bus.change_coord = 2'b10;
         tick();
         bus.change_coord = 2'b00;
         checks++;
         if (bus.visible[1] !== (k >= 4)) begin
            failures++; $display("FAIL ignored_req t+%0d got=%b exp=%b", k + 1, bus.visible[1], (k >= 4));
         end
      end
   endtask

   task automatic test_simultaneous();
      bus.change_coord = 2'b11;
      tick();
      bus.change_coord = 2'b00;
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++;
         if (bus.visible !== ((k == 4) ? 2'b11 : 2'b00)) begin
            failures++; $display("FAIL simul_visible t+%0d got=%b", k + 1, bus.visible);
         end
      end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (got_pair(i) !== exp_pair(i, m_prev)) begin
            failures++; $display("FAIL simul_offsets pair%0d got=%h exp=%h", i, got_pair(i), exp_pair(i, m_prev));
         end
      end
   endtask

   task automatic test_level();
      bus.change_coord = 2'b01;
      for (int k = 1; k <= 10; k++) begin
         tick();
         checks++;
         if (bus.visible[0] !== (k % 5 == 0)) begin
            failures++; $display("FAIL level_retrigger t+%0d got=%b exp=%b", k, bus.visible[0], (k % 5 == 0));
         end
      end
      bus.change_coord = 2'b00;
      tick();
      checks++;
      if (bus.visible !== 2'b11) begin failures++; $display("FAIL level_release got=%b exp=11", bus.visible); end
   endtask

   task automatic test_zero_seed_reset();
      resetN = 1'b0;
      seed   = 16'h0000;
      tick();
      resetN = 1'b1;
      tick();
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (got_pair(i) !== exp_pair(i, 16'hACE1)) begin
            failures++; $display("FAIL zero_seed pair%0d got=%h exp=%h", i, got_pair(i), exp_pair(i, 16'hACE1));
         end
      end
      bus.change_coord = 2'b01;
      tick();
      bus.change_coord = 2'b00;
      tick();
      resetN = 1'b0;
      #1;
      checks++;
      if ({got_pair(0), got_pair(1)} !== 88'h0) begin
         failures++; $display("FAIL midhide_reset_offsets got=%h exp=0", {got_pair(0), got_pair(1)});
      end
      checks++;
      if (bus.visible !== 2'b00) begin failures++; $display("FAIL midhide_reset_visible got=%b exp=00", bus.visible); end
      seed = 16'h0001;
      tick();
      resetN = 1'b1;
      tick();
      checks++;
      if (bus.visible !== 2'b11) begin failures++; $display("FAIL midhide_place_visible got=%b exp=11", bus.visible); end
      checks++;
      if (got_pair(0) !== exp_pair(0, 16'h0001)) begin
         failures++; $display("FAIL midhide_place_offsets got=%h exp=%h", got_pair(0), exp_pair(0, 16'h0001));
      end
   endtask

   initial begin
      test_reset();
      test_move();
      test_pause();
      test_ignored();
      test_simultaneous();
      test_level();
      test_zero_seed_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
